// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
//
// Shares a single width-bit adder among N requesters. A round-robin grant
// picks one requester in IDLE. Its operands are registered, the sum is
// computed in ADD, and the tagged result is held in RESP until the consumer
// takes it. A new grant can only follow once the response has been accepted,
// so the minimum issue interval is three cycles.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [N]        requester i presents operands
//   req_ready  [N]        one-hot grant, only ever high in IDLE
//   req_a      [N*width]  operand a of requester i at [i*width +: width]
//   req_b      [N*width]  operand b, packed like req_a
//   req_ci     [N]        carry-in of requester i
//   rsp_valid             result available
//   rsp_ready             consumer accepts the result
//   rsp_id     [IDW]      index of the requester owning the result
//   rsp_s      [width]    sum
//   rsp_co                carry-out
// ---------------------------------------------------------------------------
module adder_rr_arbiter #(
    parameter int width = 32,
    parameter int N     = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*width-1:0]   req_a,
    input  logic [N*width-1:0]   req_b,
    input  logic [N-1:0]         req_ci,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [width-1:0]     rsp_s,
    output logic                 rsp_co
);

    localparam int SW = width + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [IDW-1:0]     ptr_reg;
    logic [IDW-1:0]     ptr_next;
    logic [IDW-1:0]     grant_idx;
    logic               any_valid;
    logic               accept;

    logic [width-1:0]   a_reg;
    logic [width-1:0]   b_reg;
    logic               ci_reg;
    logic [IDW-1:0]     g_reg;

    logic               rsp_valid_reg;
    logic [IDW-1:0]     rsp_id_reg;
    logic [width-1:0]   rsp_s_reg;
    logic               rsp_co_reg;

    // Unpacked views of the packed operand buses.
    logic [width-1:0]   a_arr [N];
    logic [width-1:0]   b_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*width +: width];
            assign b_arr[gi] = req_b[gi*width +: width];
        end
    endgenerate

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    assign ptr_next = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);

    // Next-state and grant. req_ready is held low while rst is high so a
    // requester never sees a handshake that the reset is about to discard.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_valid && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_next           = ADD;
                end
            end
            ADD: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            ci_reg        <= 1'b0;
            g_reg         <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_s_reg     <= '0;
            rsp_co_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= a_arr[grant_idx];
                b_reg   <= b_arr[grant_idx];
                ci_reg  <= req_ci[grant_idx];
                g_reg   <= grant_idx;
                ptr_reg <= ptr_next;
            end
            if (state_reg == ADD) begin
                // Widen before adding so the carry out of the top bit is kept.
                {rsp_co_reg, rsp_s_reg} <= {1'b0, a_reg} + {1'b0, b_reg} + SW'(ci_reg);
                rsp_id_reg              <= g_reg;
                rsp_valid_reg           <= 1'b1;
            end
            if (state_reg == RESP && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_s     = rsp_s_reg;
    assign rsp_co    = rsp_co_reg;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_arbiter
//
// Directed and randomized bench for adder_rr_arbiter (width=32, N=4).
// The reference model keeps only a pointer integer, picks the grant by a
// modular scan of the request mask and computes sums with 33-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_adder_rr_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic [N-1:0]       req_ci;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_s;
    logic               rsp_co;

    logic [W-1:0]       a_op [N];
    logic [W-1:0]       b_op [N];
    logic               ci_op [N];

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;
    int waits [N];

    adder_rr_arbiter #(.width(W), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co)
    );

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[gi*W +: W] = a_op[gi];
            assign req_b[gi*W +: W] = b_op[gi];
            assign req_ci[gi]       = ci_op[gi];
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First set bit of v scanning upward from p with wrap-around.
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mptr = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
        chk({tag, "_rsp_sum"},   64'({rsp_co, rsp_s}), 64'd0);
    endtask

    // One full transaction from IDLE. Called at posedge+1; returns at
    // posedge+1 of the edge where the response was accepted.
    task automatic run_grant(input logic [N-1:0] vmask, input int stall, output int id_obs);
        int           g;
        logic [W:0]   exp;
        logic [63:0]  onehot;
        req_valid = vmask;
        #1;
        g      = model_grant(vmask, mptr);
        onehot = 64'd1 << g;
        exp    = {1'b0, a_op[g]} + {1'b0, b_op[g]} + (W+1)'(ci_op[g]);
        chk("grant", 64'(req_ready), onehot);
        @(posedge clk);
        #1;
        mptr      = (g + 1) % N;
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        chk("add_req_ready", 64'(req_ready), 64'd0);
        chk("add_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        id_obs    = int'(rsp_id);
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_id",    64'(rsp_id),    64'(g));
        chk("rsp_sum",   64'({rsp_co, rsp_s}), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid",     64'(rsp_valid), 64'd1);
            chk("hold_id",        64'(rsp_id),    64'(g));
            chk("hold_sum",       64'({rsp_co, rsp_s}), 64'(exp));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int             g_obs;
        logic [N-1:0]   pending;
        logic [N-1:0]   fresh;

        for (int i = 0; i < N; i++) begin
            a_op[i]  = '0;
            b_op[i]  = '0;
            ci_op[i] = 1'b0;
            waits[i] = 0;
        end

        // Reset state and an idle stretch with nothing requested.
        do_reset();
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("idle");

        // Single request from requester 2.
        a_op[2] = 32'h1234_5678; b_op[2] = 32'h1111_1111; ci_op[2] = 1'b1;
        run_grant(4'b0100, 0, g_obs);
        // Pointer now at 3: with all requesting, 3 wins.
        for (int i = 0; i < N; i++) begin
            a_op[i] = $urandom; b_op[i] = $urandom; ci_op[i] = 1'($urandom_range(0, 1));
        end
        run_grant(4'b1111, 0, g_obs);
        chk("ptr_after_2", 64'(g_obs), 64'd3);

        // Carry edge cases.
        a_op[0] = 32'hFFFF_FFFF; b_op[0] = 32'h0000_0000; ci_op[0] = 1'b1;
        run_grant(4'b0001, 0, g_obs);
        a_op[1] = 32'hFFFF_FFFF; b_op[1] = 32'hFFFF_FFFF; ci_op[1] = 1'b1;
        run_grant(4'b0010, 0, g_obs);

        // Backpressure for 5 cycles, other requesters waiting.
        a_op[2] = $urandom; b_op[2] = $urandom; ci_op[2] = 1'b0;
        run_grant(4'b1101 | 4'b0100, 5, g_obs);

        // Reset while a response is pending: requester 2 in flight, ptr -> 3.
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mptr = 0;
        chk_idle_outputs("rst_resp");
        @(posedge clk);
        #1;
        chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
        // With ptr reset to 0, requester 1 beats requester 3.
        a_op[1] = $urandom; b_op[1] = $urandom; ci_op[1] = 1'b1;
        run_grant(4'b1010, 0, g_obs);
        chk("post_reset_id", 64'(g_obs), 64'd1);

        // Round robin from reset with everyone requesting.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_op[i] = $urandom; b_op[i] = $urandom; ci_op[i] = 1'($urandom_range(0, 1));
        end
        for (int r = 0; r < 5; r++) begin
            run_grant(4'b1111, 0, g_obs);
            chk("rr_order", 64'(g_obs), 64'(r % N));
        end

        // Randomized rounds: requesters hold requests until served.
        pending = '0;
        for (int r = 0; r < 20; r++) begin
            fresh = 4'($urandom_range(0, 15)) & ~pending;
            if ((pending | fresh) == '0) fresh[$urandom_range(0, N-1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (fresh[i]) begin
                    case ($urandom_range(0, 3))
                        0:       a_op[i] = 32'hFFFF_FFFF;
                        1:       a_op[i] = 32'h0;
                        default: a_op[i] = $urandom;
                    endcase
                    b_op[i]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    ci_op[i] = 1'($urandom_range(0, 1));
                    waits[i] = 0;
                end
            end
            pending = pending | fresh;
            run_grant(pending, $urandom_range(0, 2), g_obs);
            chk("fair", 64'(waits[g_obs] < N), 64'd1);
            pending[g_obs] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (pending[i]) waits[i]++;
            end
        end
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
